// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage for the ARM pipeline. Runs 32-bit loads and stores against an
// external 16-bit asynchronous SRAM as two half-word transfers (low half
// first), and holds ready low so the pipeline freezes while an access runs.
module mem_stage_sram_ctrl #(
    parameter int ACCESS_CYCLES = 3,
    parameter int DATA_BASE     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReadEn,
    input  logic        memWriteEn,
    input  logic [31:0] aluResult,
    input  logic [31:0] valRm,
    output logic        ready,
    output logic [31:0] memReadData,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N
);

    localparam int CNT_W = $clog2(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             op_write;
    logic [16:0]      word_addr;
    logic [31:0]      wr_data;
    logic [31:0]      a;
    logic             req;
    logic             start;
    logic             cnt_last;
    logic             in_xfer;
    logic             drive_dq;
    logic [15:0]      dq_out;
    logic             unused_addr_bits;

    // Byte offset into the SRAM window; only a[18:2] selects a word, the
    // rest is dropped so the address wraps silently.
    assign a                = aluResult - 32'(DATA_BASE);
    assign unused_addr_bits = ^{a[31:19], a[1:0]};

    assign req      = memReadEn | memWriteEn;
    assign start    = (state == IDLE) && req;
    assign cnt_last = (cnt == CNT_LAST);
    assign in_xfer  = (state == LOW) || (state == HIGH);
    assign dq_out   = (state == HIGH) ? wr_data[31:16] : wr_data[15:0];
    assign SRAM_DQ  = drive_dq ? dq_out : 16'hzzzz;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state, ready and SRAM strobe decode; WE_N rises on the last
    // cycle of a write half so address and data are held past the strobe.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        SRAM_WE_N = 1'b1;
        drive_dq  = 1'b0;
        case (state)
            IDLE: begin
                if (req) state_nxt = LOW;
                else     ready     = 1'b1;
            end
            LOW: begin
                if (cnt_last) state_nxt = HIGH;
                if (op_write) begin
                    drive_dq  = 1'b1;
                    SRAM_WE_N = cnt_last;
                end
            end
            HIGH: begin
                if (cnt_last) state_nxt = DONE;
                if (op_write) begin
                    drive_dq  = 1'b1;
                    SRAM_WE_N = cnt_last;
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-half cycle counter, cleared whenever no transfer is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt <= '0;
        else if (!in_xfer) cnt <= '0;
        else if (cnt_last) cnt <= '0;
        else               cnt <= cnt + CNT_W'(1);
    end

    // Operation type latched at accept; both enables high means a store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        op_write <= 1'b0;
        else if (start) op_write <= memWriteEn;
    end

    // Word address and store data latched at accept; inputs are ignored after.
    always_ff @(posedge clk) begin
        if (start) begin
            word_addr <= a[18:2];
            wr_data   <= valRm;
        end
    end

    // SRAM address: low half on accept, high half when LOW ends, else held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           SRAM_ADDR <= '0;
        else if (start)                    SRAM_ADDR <= {a[18:2], 1'b0};
        else if (state == LOW && cnt_last) SRAM_ADDR <= {word_addr, 1'b1};
    end

    // Load capture on the edge that ends each read half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memReadData <= '0;
        end else if (!op_write && cnt_last) begin
            if (state == LOW)  memReadData[15:0]  <= SRAM_DQ;
            if (state == HIGH) memReadData[31:16] <= SRAM_DQ;
        end
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Memory stage of the ARM pipeline, directly downstream of the execute stage. It consumes the execute-stage ALU result as the data address and `valRm` as store data, and performs 32-bit loads and stores against an external 16-bit asynchronous SRAM, splitting each access into two half-word transfers. While an access is in progress it drops `ready` so that the pipeline freezes.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 3: cycles spent on each 16-bit half transfer (≥2).
- `DATA_BASE`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `memReadEn` in 1: load request from the EXE/MEM register.
- `memWriteEn` in 1: store request from the EXE/MEM register.
- `aluResult` in 32: byte address produced by the execute stage.
- `valRm` in 32: store data.
- `ready` out 1: access complete or no access pending. Low means freeze every pipeline register and the PC.
- `memReadData` out 32: last loaded word, registered.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_DQ` inout 16: SRAM data bus, high-Z unless writing.
- `SRAM_WE_N` out 1: write strobe, active low.

## Operation
- Address mapping: `a = aluResult - DATA_BASE`, computed mod 2^32. `SRAM_ADDR = {a[18:2], h}`, where h=0 for the low half (bits 15:0) and h=1 for the high half (bits 31:16). Bits `a[1:0]` and `a[31:19]` are ignored; the address wraps silently.
- If `memReadEn` and `memWriteEn` are both high, the access is treated as a write.
- FSM states: IDLE, LOW, HIGH, DONE. A cycle counter `cnt` runs 0..`ACCESS_CYCLES-1` inside LOW and HIGH.
- IDLE with a request: latch the operation, `a[18:2]`, and `valRm`, then go to LOW with cnt=0. Inputs are ignored from then until the next IDLE.
- LOW / HIGH: cnt increments each cycle. When cnt reaches `ACCESS_CYCLES-1`, LOW moves to HIGH and HIGH moves to DONE, and cnt returns to 0.
- DONE: always returns to IDLE on the next edge.
- `ready` (combinational):
  - 1 in DONE.
  - 1 in IDLE when there is no request.
  - 0 in every other case, including IDLE with a request present.
- Write phase:
  - `SRAM_DQ` is driven with the latched data half for every cycle of the phase.
  - `SRAM_WE_N` is 0 for cnt < `ACCESS_CYCLES-1` and 1 on the last cycle, which provides data and address hold.
- Read phase:
  - `SRAM_WE_N` stays 1 and `SRAM_DQ` stays high-Z.
  - `SRAM_DQ` is sampled on the edge that ends the phase's last cycle, into `memReadData[15:0]` for LOW or `[31:16]` for HIGH.
  - `memReadData` is stable from DONE onward until the next read overwrites it.
- Writes never modify `memReadData`.
- No request: no SRAM activity, `SRAM_WE_N=1`, `SRAM_DQ` high-Z.
- Outside LOW and HIGH, `SRAM_ADDR` holds its last value (0 after reset).

## Timing
- Reset values:
  - state IDLE, cnt=0
  - `memReadData=0`, `SRAM_ADDR=0`, `SRAM_WE_N=1`, `SRAM_DQ` high-Z
  - `ready=1` provided no request is present
- Reset asserted mid-access aborts immediately to these values, even during an active write strobe.
- With a request first seen in IDLE at cycle 0:
  - `ready` is low in cycles 0 … 2·`ACCESS_CYCLES`.
  - `ready` is high in cycle 2·`ACCESS_CYCLES`+1 (DONE).
  - Stall length is 2·`ACCESS_CYCLES`+1 cycles; with the default of 3 this is 7 stalled cycles, with `ready` high in cycle 7.
- The pipeline advances on the DONE edge, so the next instruction's request is seen in IDLE one cycle later. Back-to-back memory instructions therefore cost 2·`ACCESS_CYCLES`+2 cycles each.
- The pipeline holds its inputs stable while `ready`=0, but the block relies only on values latched in IDLE.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `SRAM_WE_N`=1, DQ high-Z, `memReadData`=0, `ready`=1 with no request, all without waiting for a clock edge.
- Store: `aluResult`=1028, `valRm`=0xDEADBEEF, `memWriteEn`=1 →
  - `SRAM_ADDR`=2 with DQ=0xBEEF, then `SRAM_ADDR`=3 with DQ=0xDEAD.
  - `SRAM_WE_N` low for 2 cycles per half.
  - `ready` low for exactly 7 cycles.
- Load: the SRAM model holds 0x1234 at address 2 and 0x5678 at address 3; `memReadEn` with `aluResult`=1028 → `memReadData`=0x56781234 in DONE, `SRAM_WE_N` never low.
- Store then load at `aluResult`=2000 with `valRm`=0x0000FFFF → read returns 0x0000FFFF; `SRAM_ADDR` is 488 then 489.
- Both enables high with `aluResult`=1024 → write performed at addresses 0 and 1; `memReadData` unchanged.
- Reset during the HIGH phase of a read, followed by a new read of address 1032 → state is IDLE after reset; the new read completes in 7 stall cycles with the correct data; no stray write strobe at any point.
